// File: rtl/fault_cov_monitor.sv
`default_nettype none
// ============================================================================
// Module   : fault_cov_monitor
// Brief    : Per-fault pattern sweep controller that tallies detected and
//            undetected injected faults by comparing faulty vs fault-free CUT.
// Revision : 1.0
// ============================================================================
module fault_cov_monitor #(
    parameter int OUT_BITS = 2,
    parameter int NUM_PAT  = 32,
    parameter int PAT_W    = 8,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OUT_BITS-1:0] CUT_OP,
    input  logic [OUT_BITS-1:0] FF_OP,
    input  logic                FIL_END,
    output logic                FIL_INC,
    output logic                PAT_EN,
    output logic [CNT_W-1:0]    DET_CNT,
    output logic [CNT_W-1:0]    UNDET_CNT,
    output logic [CNT_W-1:0]    FAULT_CNT,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_NEXT   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [PAT_W-1:0] c_last_pat = PAT_W'(NUM_PAT - 1);
    localparam logic [PAT_W-1:0] c_pat_one  = PAT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PAT_W-1:0] r_pat_cnt;
    logic             r_detected;
    logic [CNT_W-1:0] r_det_cnt;
    logic [CNT_W-1:0] r_undet_cnt;
    logic [CNT_W-1:0] r_fault_cnt;
    logic             w_mismatch;
    logic             w_last_pat;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

    assign w_mismatch = |(CUT_OP ^ FF_OP);
    assign w_last_pat = (r_pat_cnt == c_last_pat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Mismatch is tested before exhaustion so a hit on the final pattern is detected.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
            S_RUN:          if (w_mismatch || w_last_pat) w_state_nxt = S_NEXT;
            S_NEXT:         w_state_nxt = FIL_END ? S_DONE : S_SETTLE;
            S_SETTLE:       w_state_nxt = S_RUN;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat_cnt   <= '0;
            r_detected  <= 1'b0;
            r_det_cnt   <= '0;
            r_undet_cnt <= '0;
            r_fault_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_pat_cnt   <= '0;
                        r_det_cnt   <= '0;
                        r_undet_cnt <= '0;
                        r_fault_cnt <= '0;
                    end
                end
                S_RUN: begin
                    if (w_mismatch)      r_detected <= 1'b1;
                    else if (w_last_pat) r_detected <= 1'b0;
                    else                 r_pat_cnt  <= r_pat_cnt + c_pat_one;
                end
                S_NEXT: begin
                    r_fault_cnt <= sat_inc(r_fault_cnt);
                    if (r_detected) r_det_cnt   <= sat_inc(r_det_cnt);
                    else            r_undet_cnt <= sat_inc(r_undet_cnt);
                end
                S_SETTLE: r_pat_cnt <= '0;
                default: ;
            endcase
        end
    end

    // Control outputs decode state only; FIL_END is the sole non-state term.
    assign PAT_EN    = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) || (r_state == S_NEXT) || (r_state == S_SETTLE);
    assign done      = (r_state == S_DONE);
    assign FIL_INC   = (r_state == S_NEXT) && !FIL_END;
    assign DET_CNT   = r_det_cnt;
    assign UNDET_CNT = r_undet_cnt;
    assign FAULT_CNT = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fault_cov_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_cov_monitor
// Brief    : Campaign-plan driven bench for fault_cov_monitor (default and
//            2-bit tally instances sharing the same stimulus).
// Revision : 1.0
// ============================================================================
module tb_fault_cov_monitor;

    localparam int OUT_BITS = 2;
    localparam int NUM_PAT  = 32;
    localparam int PAT_W    = 8;
    localparam int CNT_W    = 8;
    localparam int CNT_W_S  = 2;
    localparam int NEVER    = 1000;
    localparam int P_IDLE   = 0;
    localparam int P_RUN    = 1;
    localparam int P_NEXT   = 2;
    localparam int P_SETTLE = 3;
    localparam int P_DONE   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                FIL_END = 1'b0;
    logic [OUT_BITS-1:0] CUT_OP = '0;
    logic [OUT_BITS-1:0] FF_OP = '0;

    logic               fil_inc_a, pat_en_a, busy_a, done_a;
    logic [CNT_W-1:0]   det_a, undet_a, fault_a;
    logic               fil_inc_b, pat_en_b, busy_b, done_b;
    logic [CNT_W_S-1:0] det_b, undet_b, fault_b;

    fault_cov_monitor #(
        .OUT_BITS(OUT_BITS), .NUM_PAT(NUM_PAT), .PAT_W(PAT_W), .CNT_W(CNT_W)
    ) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .CUT_OP(CUT_OP), .FF_OP(FF_OP),
        .FIL_END(FIL_END), .FIL_INC(fil_inc_a), .PAT_EN(pat_en_a),
        .DET_CNT(det_a), .UNDET_CNT(undet_a), .FAULT_CNT(fault_a),
        .busy(busy_a), .done(done_a)
    );

    fault_cov_monitor #(
        .OUT_BITS(OUT_BITS), .NUM_PAT(NUM_PAT), .PAT_W(PAT_W), .CNT_W(CNT_W_S)
    ) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .CUT_OP(CUT_OP), .FF_OP(FF_OP),
        .FIL_END(FIL_END), .FIL_INC(fil_inc_b), .PAT_EN(pat_en_b),
        .DET_CNT(det_b), .UNDET_CNT(undet_b), .FAULT_CNT(fault_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    // Model: true (unsaturated) tallies plus the planned phase of the current cycle.
    int m_det = 0, m_undet = 0, m_fault = 0;
    int e_ph = P_IDLE;
    bit e_fe = 1'b0;
    bit chk_en = 1'b0;
    int idle_ph = P_IDLE;
    int plan [16];
    bit force_settle_mis = 1'b0;
    bit abort_next = 1'b0;
    int fil_inc_seen = 0, pat_en_seen = 0;

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int ep, eb, ed, ef;
            ep = (e_ph == P_RUN) ? 1 : 0;
            eb = (e_ph == P_RUN || e_ph == P_NEXT || e_ph == P_SETTLE) ? 1 : 0;
            ed = (e_ph == P_DONE) ? 1 : 0;
            ef = (e_ph == P_NEXT && !e_fe) ? 1 : 0;
            chk("pat_en_a", 32'(pat_en_a), ep);
            chk("busy_a", 32'(busy_a), eb);
            chk("done_a", 32'(done_a), ed);
            chk("fil_inc_a", 32'(fil_inc_a), ef);
            chk("det_a", 32'(det_a), sat(m_det, 255));
            chk("undet_a", 32'(undet_a), sat(m_undet, 255));
            chk("fault_a", 32'(fault_a), sat(m_fault, 255));
            chk("pat_en_b", 32'(pat_en_b), ep);
            chk("busy_b", 32'(busy_b), eb);
            chk("done_b", 32'(done_b), ed);
            chk("fil_inc_b", 32'(fil_inc_b), ef);
            chk("det_b", 32'(det_b), sat(m_det, 3));
            chk("undet_b", 32'(undet_b), sat(m_undet, 3));
            chk("fault_b", 32'(fault_b), sat(m_fault, 3));
            if (pat_en_a === 1'b1) pat_en_seen++;
            if (fil_inc_a === 1'b1) fil_inc_seen++;
        end
    end

    function automatic bit rs();
        return ($urandom_range(0, 5) == 0);
    endfunction

    task automatic set_inputs(input bit st, input bit mis, input bit fe, input int ph);
        logic [OUT_BITS-1:0] ff, flip;
        ff   = OUT_BITS'($urandom);
        flip = OUT_BITS'($urandom_range(1, 2**OUT_BITS - 1));
        start   = st;
        FIL_END = fe;
        FF_OP   = ff;
        CUT_OP  = mis ? (ff ^ flip) : ff;
        e_ph    = ph;
        e_fe    = fe;
    endtask

    task automatic drive(input bit st, input bit mis, input bit fe, input int ph);
        set_inputs(st, mis, fe, ph);
        @(posedge clk);
        #1;
    endtask

    task automatic campaign(input int nf);
        bit from_done;
        bit fe, mis;
        from_done = (idle_ph == P_DONE);
        drive(1'b1, 1'($urandom), 1'b0, idle_ph);
        m_det = 0; m_undet = 0; m_fault = 0;
        if (from_done) begin
            chk("restart_clear_det", 32'(det_a), 0);
            chk("restart_clear_fault", 32'(fault_a), 0);
        end
        for (int f = 0; f < nf; f++) begin
            fe = (f == nf - 1);
            for (int k = 0; k < NUM_PAT; k++) begin
                mis = (k == plan[f]);
                drive((k == 1) || rs(), mis, fe, P_RUN);
                if (mis) break;
            end
            if (abort_next && !fe) begin
                set_inputs(rs(), 1'($urandom), 1'b0, P_NEXT);
                #2;
                rst = 1'b0;
                e_ph = P_IDLE;
                m_det = 0; m_undet = 0; m_fault = 0;
                #1;
                chk("abort_fil_inc", 32'(fil_inc_a), 0);
                chk("abort_busy", 32'(busy_a), 0);
                chk("abort_done", 32'(done_a), 0);
                chk("abort_pat_en", 32'(pat_en_a), 0);
                chk("abort_fault", 32'(fault_a), 0);
                @(posedge clk);
                #1;
                idle_ph = P_IDLE;
                return;
            end
            drive(rs(), 1'($urandom), fe, P_NEXT);
            m_fault++;
            if (plan[f] < NUM_PAT) m_det++;
            else                   m_undet++;
            if (!fe)
                drive(rs(), force_settle_mis | 1'($urandom), (f + 1 == nf - 1), P_SETTLE);
        end
        idle_ph = P_DONE;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom), idle_ph);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(2);

        // Faults detected on pattern 0, pattern 5, and never.
        plan[0] = 0; plan[1] = 5; plan[2] = NEVER;
        fil_inc_seen = 0;
        campaign(3);
        chk("t1_det", 32'(det_a), 2);
        chk("t1_undet", 32'(undet_a), 1);
        chk("t1_fault", 32'(fault_a), 3);
        chk("t1_fil_inc_pulses", 32'(fil_inc_seen), 2);
        chk("t1_done", 32'(done_a), 1);
        idle_cycles(3);

        // Single fault hit only on the last pattern.
        plan[0] = NUM_PAT - 1;
        pat_en_seen = 0;
        campaign(1);
        chk("t2_det", 32'(det_a), 1);
        chk("t2_undet", 32'(undet_a), 0);
        chk("t2_pat_en_cycles", 32'(pat_en_seen), 32);
        idle_cycles(2);

        // Mismatch only while settling must not count for the next fault.
        plan[0] = 3; plan[1] = NEVER;
        force_settle_mis = 1'b1;
        campaign(2);
        force_settle_mis = 1'b0;
        chk("t3_undet", 32'(undet_a), 1);
        chk("t3_det", 32'(det_a), 1);
        idle_cycles(2);

        // Five detected faults saturate the 2-bit tallies.
        for (int i = 0; i < 5; i++) plan[i] = i;
        campaign(5);
        chk("t4_det_b_sat", 32'(det_b), 3);
        chk("t4_fault_b_sat", 32'(fault_b), 3);
        chk("t4_det_a", 32'(det_a), 5);
        chk("t4_fault_a", 32'(fault_a), 5);
        idle_cycles(2);

        for (int r = 0; r < 6; r++) begin
            int nf;
            nf = $urandom_range(1, 8);
            for (int i = 0; i < nf; i++) begin
                plan[i] = $urandom_range(0, NUM_PAT + 8);
                if ($urandom_range(0, 7) == 0) plan[i] = NUM_PAT - 1;
            end
            campaign(nf);
            idle_cycles($urandom_range(1, 4));
        end

        // Reset asserted during a non-final NEXT cycle.
        plan[0] = 2; plan[1] = NEVER;
        abort_next = 1'b1;
        campaign(2);
        abort_next = 1'b0;
        idle_cycles(2);
        rst = 1'b1;
        idle_cycles(3);
        chk("post_abort_busy", 32'(busy_a), 0);
        chk("post_abort_done", 32'(done_a), 0);

        plan[0] = NEVER;
        campaign(1);
        chk("recover_undet", 32'(undet_a), 1);
        idle_cycles(2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fault_cov_monitor.md
FAULT_COV_MONITOR -- requirements
Module: fault_cov_monitor

Interface
REQ-001 SHALL have parameter OUT_BITS, default 2, width of the CUT_OP/FF_OP buses compared.
REQ-002 SHALL have parameter NUM_PAT, default 32, the maximum number of test patterns applied per injected fault (range 1 to 2**PAT_W).
REQ-003 SHALL have parameter PAT_W, default 8, pattern counter width.
REQ-004 SHALL have parameter CNT_W, default 8, width of the fault tally counters.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clk, input, 1, rising-edge clock.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, one-cycle request to begin a campaign.
REQ-009 SHALL have ports CUT_OP and FF_OP, input, OUT_BITS, faulty and fault-free CUT outputs from the mid section.
REQ-010 SHALL have port FIL_END, input, 1, high when the currently injected fault is the last one.
REQ-011 SHALL have port FIL_INC, output, 1, one-cycle pulse requesting the next fault.
REQ-012 SHALL have port PAT_EN, output, 1, advance enable to the upstream pattern generator.
REQ-013 SHALL have ports DET_CNT, UNDET_CNT and FAULT_CNT, output, CNT_W, detected, undetected and total faults.
REQ-014 SHALL have ports busy and done, output, 1, campaign running and campaign complete.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, NEXT, SETTLE and DONE, all registered.
REQ-016 IDLE: on start=1, clear pat_cnt, DET_CNT, UNDET_CNT and FAULT_CNT, then enter RUN on the next edge.
REQ-017 RUN: PAT_EN=1; each cycle compare CUT_OP against FF_OP; mismatch means any bit differs.
REQ-018 RUN, mismatch: mark the fault detected, enter NEXT, and do not increment pat_cnt.
REQ-019 RUN, no mismatch and pat_cnt==NUM_PAT-1: mark the fault undetected and enter NEXT.
REQ-020 RUN, otherwise: increment pat_cnt and stay in RUN.
REQ-021 A mismatch on the last pattern (pat_cnt==NUM_PAT-1) SHALL count as detected; mismatch takes priority over exhaustion.
REQ-022 NEXT, one cycle, PAT_EN=0: increment FAULT_CNT and exactly one of DET_CNT/UNDET_CNT.
REQ-023 NEXT, FIL_END=1: go to DONE with no FIL_INC pulse.
REQ-024 NEXT, FIL_END=0: FIL_INC=1 for exactly this cycle, then go to SETTLE.
REQ-025 SETTLE, one cycle, PAT_EN=0: clear pat_cnt and let the new fault propagate; comparison is ignored here. Next state RUN.
REQ-026 DONE: done=1, counters held; on start=1 behave as in IDLE and enter RUN; otherwise stay.
REQ-027 busy SHALL be 1 in RUN, NEXT and SETTLE, and 0 in IDLE and DONE.
REQ-028 start while busy=1 SHALL be ignored.
REQ-029 Counters SHALL saturate at 2**CNT_W-1, and DET_CNT+UNDET_CNT==FAULT_CNT SHALL hold whenever no counter is saturated.
REQ-030 FIL_INC, PAT_EN, busy and done SHALL be registered or decoded from state only, with no combinational path from CUT_OP/FF_OP.
REQ-031 Comparison SHALL use the CUT_OP/FF_OP values sampled on the same edge the state decision is made.

Reset
REQ-032 On rst=0, asynchronously: state=IDLE, pat_cnt=0, DET_CNT=UNDET_CNT=FAULT_CNT=0, FIL_INC=0, PAT_EN=0, busy=0, done=0.
REQ-033 Reset asserted mid-campaign SHALL abort with no FIL_INC pulse emitted; on release the block waits in IDLE for start.

Verification
REQ-034 Three faults, with mismatch on pattern 0, pattern 5 and never, NUM_PAT=32, FIL_END high on the third -> DET_CNT=2, UNDET_CNT=1, FAULT_CNT=3, two FIL_INC pulses, done=1.
REQ-035 Mismatch only on pattern 31 (NUM_PAT=32), single fault, FIL_END=1 -> DET_CNT=1, UNDET_CNT=0, 32 PAT_EN cycles counted.
REQ-036 Mismatch injected during SETTLE only, then clean patterns -> fault counted undetected, UNDET_CNT=1.
REQ-037 start pulsed during RUN -> no counter clear and no state change; after DONE a new start clears the counters to 0 and runs again.
REQ-038 rst=0 asserted in NEXT with FIL_END=0 -> FIL_INC stays 0, all outputs 0, state IDLE.
REQ-039 CNT_W=2 with 5 detected faults -> DET_CNT saturates at 3 and FAULT_CNT saturates at 3.
